playlist_mcu: RTL

Parametrised successor to the music-player control unit. Owns the song index, play/pause state and the player-reset pulse for a playlist of `NUM_SONGS` tracks. It adds previous-track navigation, end-of-song modes (stop, continue, repeat-one) and optional shuffle. It sits between the button one-pulsers and the song/note player; the player consumes `play`, `reset_player` and `song`, and returns `song_done`.

---
 rtl/playlist_pkg.sv | 7 +
 rtl/playlist_mcu_if.sv | 18 +
 rtl/lfsr8.sv | 14 +
 rtl/playlist_mcu.sv | 83 ++++++++
 4 files changed

// File: rtl/playlist_pkg.sv
// playlist_pkg: shared types and constants for playlist_mcu.
// Holds the FSM state enum, the end_mode encodings and the LFSR seed.
package playlist_pkg;
    typedef enum logic [1:0] {PAUSED, PLAYING, RST_PAUSE, RST_PLAY} state_t;
    typedef enum logic [1:0] {END_STOP = 2'd0, END_CONTINUE = 2'd1, END_REPEAT_ONE = 2'd2} end_mode_t;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
endpackage

// File: rtl/playlist_mcu_if.sv
// playlist_mcu_if: bundle between the button pulsers, the song player and playlist_mcu.
// master drives play_button/next_button/prev_button/song_done/end_mode/shuffle and
// receives play/reset_player/song; slave is the playlist_mcu side.
interface playlist_mcu_if #(parameter int SONG_W = 2);
    logic              play_button;
    logic              next_button;
    logic              prev_button;
    logic              song_done;
    logic [1:0]        end_mode;
    logic              shuffle;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    modport master (output play_button, next_button, prev_button, song_done, end_mode, shuffle,
                    input play, reset_player, song);
    modport slave  (input play_button, next_button, prev_button, song_done, end_mode, shuffle,
                    output play, reset_player, song);
endinterface

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Ports: clk, reset_n (async active-low, loads LFSR_SEED), en (advance), q (state).
module lfsr8
    import playlist_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) q <= LFSR_SEED;
        else if (en)  q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/playlist_mcu.sv
// playlist_mcu: song index, play/pause and player-reset control for NUM_SONGS tracks.
// Ports: clk, reset_n (async active-low), bus (playlist_mcu_if.slave: buttons, song_done,
// end_mode, shuffle in; play, reset_player, song out). Define PLAYLIST_MCU_SHUFFLE_EN to
// build the LFSR-driven shuffled next-song order.
module playlist_mcu
    import playlist_pkg::*;
#(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = $clog2(NUM_SONGS)
)(
    input  logic                 clk,
    input  logic                 reset_n,
    playlist_mcu_if.slave        bus
);
    state_t            state;
    logic [SONG_W-1:0] song;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] seq_nxt;
    logic [SONG_W-1:0] prv_idx;
    logic [SONG_W-1:0] nxt_idx;

    assign seq_nxt = (song == SONG_W'(NUM_SONGS - 1)) ? '0 : song + 1'b1;
    assign prv_idx = (song == '0) ? SONG_W'(NUM_SONGS - 1) : song - 1'b1;

`ifdef PLAYLIST_MCU_SHUFFLE_EN
    logic [7:0]        lfsr;
    logic [SONG_W-1:0] rnd;
    lfsr8 u_lfsr (.clk(clk), .reset_n(reset_n), .en(1'b1), .q(lfsr));
    assign rnd     = SONG_W'(32'(lfsr) % NUM_SONGS);
    // A shuffle hit on the current song would look like a no-op, so step instead.
    assign nxt_idx = (bus.shuffle && rnd != song) ? rnd : seq_nxt;
`else
    logic unused_shuffle;
    assign unused_shuffle = bus.shuffle;
    assign nxt_idx        = seq_nxt;
`endif

    // Outputs are registered alongside the state so they always match the state entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PAUSED;
            song         <= '0;
            play         <= 1'b0;
            reset_player <= 1'b0;
        end else begin
            play         <= 1'b0;
            reset_player <= 1'b0;
            case (state)
                PAUSED:
                    if (bus.next_button) begin
                        song <= nxt_idx; state <= RST_PAUSE; reset_player <= 1'b1;
                    end else if (bus.prev_button) begin
                        song <= prv_idx; state <= RST_PAUSE; reset_player <= 1'b1;
                    end else if (bus.play_button) begin
                        state <= PLAYING; play <= 1'b1;
                    end
                PLAYING:
                    if (bus.song_done) begin
                        reset_player <= 1'b1;
                        if (bus.end_mode == END_REPEAT_ONE) state <= RST_PLAY;
                        else begin
                            song  <= nxt_idx;
                            state <= (bus.end_mode == END_CONTINUE) ? RST_PLAY : RST_PAUSE;
                        end
                    end else if (bus.next_button) begin
                        song <= nxt_idx; state <= RST_PAUSE; reset_player <= 1'b1;
                    end else if (bus.prev_button) begin
                        song <= prv_idx; state <= RST_PAUSE; reset_player <= 1'b1;
                    end else if (bus.play_button) state <= PAUSED;
                    else play <= 1'b1;
                RST_PAUSE: state <= PAUSED;
                default: begin
                    state <= PLAYING; play <= 1'b1;
                end
            endcase
        end
    end

    assign bus.song         = song;
    assign bus.play         = play;
    assign bus.reset_player = reset_player;
endmodule
